ps2_frame_rx: RTL and testbench

- PS/2 device-to-host serial receiver that turns raw PS2_CLK/PS2_DAT pin activity into validated 8-bit scan codes.
- Sits directly upstream of the scan-code-to-letter decoder, which turns scan codes into one-hot letters for the plugboard.
- Provides a level `scan_ready` / pulse `read` handshake, odd-parity and stop-bit checking, clock-glitch filtering, and a mid-frame timeout so a lost bit cannot wedge the receiver.

---
 rtl/ps2_frame_rx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: pin synchronisation, clock glitch filter, and
// an 11-bit frame decoder with parity/stop checking, timeout and a ready/read handshake.
module ps2_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       read,
    output logic [7:0] scan_code,
    output logic       scan_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic [FILTER_LEN-2:0]  clk_hist_q, clk_hist_d;
    logic                   filt_q, filt_d;
    logic [FILTER_LEN-1:0]  clk_window;
    logic                   clk_s, dat_s, fall;

    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign dat_s      = dat_sync_q[SYNC_STAGES-1];
    assign clk_window = {clk_hist_q, clk_s};

    always_comb begin
        clk_hist_d[0] = clk_s;
        for (int i = 1; i < FILTER_LEN - 1; i++) begin
            clk_hist_d[i] = clk_hist_q[i-1];
        end
    end

    always_comb begin
        filt_d = filt_q;
        if (&clk_window) begin
            filt_d = 1'b1;
        end else if (clk_window == '0) begin
            filt_d = 1'b0;
        end
    end

    // Falling edge is flagged in the cycle before filt_q drops, so the FSM
    // consumes the data sample on the same edge the filtered clock changes.
    assign fall = filt_q & (clk_window == '0);

    // NOTE: the conditioning chain resets to 1, the idle bus level, so that
    // leaving reset never looks like a falling edge.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_hist_q <= '1;
            filt_q     <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbour.
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
            clk_hist_q <= clk_hist_d;
            filt_q     <= filt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame decoder and handshake
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       code_q, code_d;
    logic             ready_q, ready_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             commit;

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = '0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        commit    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fall && !dat_s) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d[bit_cnt_q] = dat_s;
                    bit_cnt_d          = 3'(bit_cnt_q + 3'd1);
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = dat_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (!dat_s) begin
                        ferr_d = 1'b1;
                    end else if (^{shift_q, par_q}) begin
                        commit = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A partial frame with no falling edge for TIMEOUT_CYCLES is aborted.
        if (state_q != ST_IDLE && !fall) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                ferr_d  = 1'b1;
            end else begin
                tmo_d = TMO_W'(tmo_q + 1'b1);
            end
        end
    end

    always_comb begin
        code_d  = code_q;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        if (commit) begin
            code_d  = shift_q;
            ready_d = 1'b1;
            if (ready_q && !read) begin
                ovr_d = 1'b1;
            end
        end else if (read) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            code_q    <= '0;
            ready_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            code_q    <= code_d;
            ready_q   <= ready_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign scan_code  = code_q;
    assign scan_ready = ready_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: drives PS/2 frames on the pins and compares every cycle
// against a frame-level model, plus literal expectations after each scenario.
module tb_ps2_frame_rx;

    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 5000;
    localparam int HALF           = 20;   // compressed PS/2 half period, in CLOCK_50 cycles
    localparam int SETUP          = 10;
    localparam int HLEN           = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic       read     = 1'b0;
    logic [7:0] scan_code;
    logic       scan_ready, parity_err, frame_err, overrun;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .read      (read),
        .scan_code (scan_code),
        .scan_ready(scan_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: pin history, filtered clock, bit queue per frame
    // ------------------------------------------------------------------
    logic       m_clk_h [HLEN];
    logic       m_dat_h [HLEN];
    logic       m_filt;
    bit         m_in_frame;
    int         m_timer;
    logic       m_bits[$];
    logic [7:0] m_code;
    logic       m_ready, m_perr, m_ferr, m_ovr;
    bit         m_all0, m_all1, m_fall, m_commit;
    logic       m_samp;
    logic [7:0] m_data;
    int         m_ones;

    always @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < HLEN; j++) begin
                m_clk_h[j] = 1'b1;
                m_dat_h[j] = 1'b1;
            end
            m_filt = 1'b1; m_in_frame = 0; m_timer = 0; m_bits.delete();
            m_code = 8'h00; m_ready = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
        end else begin
            m_all0 = 1; m_all1 = 1;
            for (int j = 0; j < FILTER_LEN; j++) begin
                if (m_clk_h[SYNC_STAGES-1+j]) m_all0 = 0;
                else                          m_all1 = 0;
            end
            m_samp = m_dat_h[SYNC_STAGES-1];
            m_fall = m_all0 && m_filt;
            if (m_all0)      m_filt = 1'b0;
            else if (m_all1) m_filt = 1'b1;

            m_perr = 0; m_ferr = 0; m_commit = 0;
            if (m_in_frame) begin
                if (m_fall) begin
                    m_timer = 0;
                    m_bits.push_back(m_samp);
                    if (m_bits.size() == 10) begin
                        m_data = 8'h00;
                        for (int i = 0; i < 8; i++) m_data[i] = m_bits[i];
                        m_ones = $countones(m_data) + int'(m_bits[8]);
                        if (m_bits[9] == 1'b0)  m_ferr = 1;
                        else if (m_ones % 2 == 0) m_perr = 1;
                        else                      m_commit = 1;
                        m_in_frame = 0;
                    end
                end else begin
                    m_timer++;
                    if (m_timer == TIMEOUT_CYCLES) begin
                        m_ferr = 1; m_in_frame = 0; m_timer = 0;
                    end
                end
            end else if (m_fall && !m_samp) begin
                m_in_frame = 1; m_timer = 0; m_bits.delete();
            end

            if (m_commit) begin
                if (m_ready && !read) m_ovr = 1;
                m_code = m_data; m_ready = 1;
            end else if (read) begin
                m_ready = 0;
            end

            for (int j = HLEN - 1; j > 0; j--) begin
                m_clk_h[j] = m_clk_h[j-1];
                m_dat_h[j] = m_dat_h[j-1];
            end
            m_clk_h[0] = PS2_CLK;
            m_dat_h[0] = PS2_DAT;
        end
    end

    bit cmp_en    = 0;
    int perr_seen = 0;
    int ferr_seen = 0;

    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            check("cycle_outputs", {20'd0, scan_code, scan_ready, parity_err, frame_err, overrun},
                  {20'd0, m_code, m_ready, m_perr, m_ferr, m_ovr});
            if (parity_err === 1'b1) perr_seen++;
            if (frame_err === 1'b1)  ferr_seen++;
        end
    end

    // ------------------------------------------------------------------
    // Pin drivers
    // ------------------------------------------------------------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        PS2_DAT = b;
        wait_cyc(SETUP);
        PS2_CLK = 1'b0;
        wait_cyc(HALF);
        PS2_CLK = 1'b1;
        if (glitch) begin
            wait_cyc(8);
            PS2_CLK = 1'b0;
            wait_cyc(3);
            PS2_CLK = 1'b1;
            wait_cyc(HALF - 11);
        end else begin
            wait_cyc(HALF);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input bit bad_par, input logic stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {stop, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_bit);
        PS2_DAT = 1'b1;
        wait_cyc(4);
    endtask

    task automatic pulse_read();
        read = 1'b1;
        wait_cyc(1);
        read = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b0;
        #1;
        check("reset_code",  {24'd0, scan_code}, 32'h00);
        check("reset_flags", {28'd0, scan_ready, parity_err, frame_err, overrun}, 32'h0);
        cmp_en = 1;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(10);

        // 2-cycle low glitch on an idle bus
        PS2_CLK = 1'b0; wait_cyc(2); PS2_CLK = 1'b1;
        wait_cyc(20);
        check("idle_glitch_ready", {31'd0, scan_ready}, 32'd0);
        check("idle_glitch_ferr",  ferr_seen, 0);

        // Good 0x1C
        send_frame(8'h1C, 0, 1'b1, 11, -1);
        check("1c_code",  {24'd0, scan_code}, 32'h1C);
        check("1c_ready", {31'd0, scan_ready}, 32'd1);
        check("1c_noerr", perr_seen + ferr_seen, 0);
        pulse_read();
        check("1c_read_clears", {31'd0, scan_ready}, 32'd0);

        // Back-to-back F0, 1C with reads
        send_frame(8'hF0, 0, 1'b1, 11, -1);
        check("f0_code", {24'd0, scan_code}, 32'hF0);
        pulse_read();
        check("f0_read_clears", {31'd0, scan_ready}, 32'd0);
        check("f0_code_held", {24'd0, scan_code}, 32'hF0);
        send_frame(8'h1C, 0, 1'b1, 11, -1);
        check("b2b_1c_code", {24'd0, scan_code}, 32'h1C);
        pulse_read();
        check("b2b_overrun", {31'd0, overrun}, 32'd0);

        // 0x32 with bad parity, then with bad stop bit
        send_frame(8'h32, 1, 1'b1, 11, -1);
        check("par_pulses",   perr_seen, 1);
        check("par_ready",    {31'd0, scan_ready}, 32'd0);
        check("par_code_kept", {24'd0, scan_code}, 32'h1C);
        send_frame(8'h32, 0, 1'b0, 11, -1);
        check("stop_ferr", ferr_seen, 1);
        check("stop_perr", perr_seen, 1);

        // Partial frame: start + 4 data bits, then silence
        send_frame(8'hFF, 0, 1'b1, 5, -1);
        wait_cyc(TIMEOUT_CYCLES + 10);
        check("timeout_ferr",  ferr_seen, 2);
        check("timeout_ready", {31'd0, scan_ready}, 32'd0);
        send_frame(8'h1C, 0, 1'b1, 11, -1);
        check("post_timeout_code",  {24'd0, scan_code}, 32'h1C);
        check("post_timeout_ready", {31'd0, scan_ready}, 32'd1);
        pulse_read();

        // Mid-frame 3-cycle glitch, then a second byte with no read
        send_frame(8'h1C, 0, 1'b1, 11, 3);
        check("glitch_code", {24'd0, scan_code}, 32'h1C);
        check("glitch_ovr",  {31'd0, overrun}, 32'd0);
        send_frame(8'h5A, 0, 1'b1, 11, -1);
        check("ovr_code", {24'd0, scan_code}, 32'h5A);
        check("ovr_flag", {31'd0, overrun}, 32'd1);

        // Reset after the 6th data bit of a frame
        send_frame(8'h24, 0, 1'b1, 7, -1);
        wait_cyc(2);
        #2 reset = 1'b0;
        #1;
        check("midreset_code",  {24'd0, scan_code}, 32'h00);
        check("midreset_flags", {28'd0, scan_ready, parity_err, frame_err, overrun}, 32'h0);
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(10);
        send_frame(8'h24, 0, 1'b1, 11, -1);
        check("post_reset_code",  {24'd0, scan_code}, 32'h24);
        check("post_reset_ready", {31'd0, scan_ready}, 32'd1);
        check("post_reset_ovr",   {31'd0, overrun}, 32'd0);
        check("total_ferr", ferr_seen, 2);

        wait_cyc(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
